// File: rtl/ddr_frame_burst_writer.sv
// AXI write-burst engine that drains a FWFT pixel FIFO into a ring of DDR frame buffers.
// Supports continuous or trigger-armed single-shot capture and recovery from mid-frame restarts.
module ddr_frame_burst_writer #(
    parameter int unsigned       ADDR_W      = 28,
    parameter int unsigned       DATA_W      = 256,
    parameter int unsigned       BURST_LEN   = 16,
    parameter int unsigned       FRAME_BEATS = 57600,
    parameter int unsigned       NUM_BUF     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0] BUF_STRIDE  = ADDR_W'(32'h0020_0000),
    parameter int unsigned       CNT_W       = 10
) (
    input  logic                  ddr_clk,
    input  logic                  ddr_rstn,
    input  logic                  enable,
    input  logic                  single_shot,
    input  logic                  trig,
    input  logic                  frame_start,
    input  logic [DATA_W-1:0]     fifo_rd_data,
    input  logic [CNT_W-1:0]      fifo_count,
    output logic                  fifo_rd_en,
    output logic                  fifo_flush,
    output logic [ADDR_W-1:0]     axi_awaddr,
    output logic [3:0]            axi_awlen,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_W-1:0]     axi_wdata,
    output logic [DATA_W/8-1:0]   axi_wstrb,
    input  logic                  axi_wready,
    input  logic                  axi_wusero_last,
    output logic                  busy,
    output logic                  frame_done,
    output logic [2:0]            done_buf,
    output logic                  frame_abort,
    output logic                  last_err
);

    localparam int unsigned BURSTS      = FRAME_BEATS / BURST_LEN;
    localparam int unsigned IDX_W       = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int unsigned BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned BURST_BYTES = BURST_LEN * (DATA_W / 8);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        WAIT_DATA  = 3'd2,
        ADDR       = 3'd3,
        DATA       = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                armed_q, armed_d;
    logic                abort_q, abort_d;
    logic [IDX_W-1:0]    burst_idx_q, burst_idx_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [2:0]          cur_buf_q, cur_buf_d;
    logic [2:0]          done_buf_d;
    logic [ADDR_W-1:0]   awaddr_d;
    logic                awvalid_d;
    logic                done_d;
    logic                abort_pulse_d;
    logic                last_err_d;
    logic                busy_d;
    logic                beat_ok;
    logic                last_beat;
    logic                last_burst;
    logic                mid_frame;

    assign axi_awlen  = 4'(BURST_LEN - 1);
    assign axi_wstrb  = '1;
    assign axi_wdata  = fifo_rd_data;
    assign fifo_rd_en = (state_q == DATA) && axi_wready;

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q | trig;
        burst_idx_d   = burst_idx_q;
        beat_cnt_d    = beat_cnt_q;
        cur_buf_d     = cur_buf_q;
        done_buf_d    = done_buf;
        awaddr_d      = axi_awaddr;
        awvalid_d     = 1'b0;
        done_d        = 1'b0;
        abort_pulse_d = 1'b0;

        beat_ok    = (state_q == DATA) && axi_wready;
        last_beat  = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
        last_burst = (burst_idx_q == IDX_W'(BURSTS - 1));
        mid_frame  = (state_q == WAIT_DATA) || (state_q == ADDR) || (state_q == DATA);
        abort_d    = abort_q | (mid_frame & frame_start);
        last_err_d = last_err | (beat_ok & (axi_wusero_last != last_beat));

        case (state_q)
            IDLE: begin
                if (enable && (!single_shot || armed_d)) begin
                    state_d = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_d     = WAIT_DATA;
                    burst_idx_d = '0;
                    armed_d     = 1'b0;
                    abort_d     = 1'b0;
                end
            end
            WAIT_DATA: begin
                // A restart seen between bursts is resolved at once: nothing is in flight
                if (abort_d) begin
                    abort_pulse_d = 1'b1;
                    abort_d       = 1'b0;
                    burst_idx_d   = '0;
                end else if (fifo_count >= CNT_W'(BURST_LEN)) begin
                    state_d   = ADDR;
                    awvalid_d = 1'b1;
                    awaddr_d  = BASE_ADDR + ADDR_W'(cur_buf_q) * BUF_STRIDE
                              + ADDR_W'(burst_idx_q) * ADDR_W'(BURST_BYTES);
                end
            end
            ADDR: begin
                awvalid_d = !axi_awready;
                if (axi_awready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat_ok) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = WAIT_DATA;
                        if (abort_d) begin
                            abort_pulse_d = 1'b1;
                            abort_d       = 1'b0;
                            burst_idx_d   = '0;
                        end else if (last_burst) begin
                            done_d     = 1'b1;
                            done_buf_d = cur_buf_q;
                            cur_buf_d  = (cur_buf_q == 3'(NUM_BUF - 1)) ? 3'd0 : cur_buf_q + 3'd1;
                            state_d    = IDLE;
                        end else begin
                            burst_idx_d = burst_idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == WAIT_DATA) || (state_d == ADDR) || (state_d == DATA);
    end

    // State and registered outputs
    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            abort_q     <= 1'b0;
            burst_idx_q <= '0;
            beat_cnt_q  <= '0;
            cur_buf_q   <= '0;
            done_buf    <= '0;
            axi_awaddr  <= BASE_ADDR;
            axi_awvalid <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            fifo_flush  <= 1'b0;
            last_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            abort_q     <= abort_d;
            burst_idx_q <= burst_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            cur_buf_q   <= cur_buf_d;
            done_buf    <= done_buf_d;
            axi_awaddr  <= awaddr_d;
            axi_awvalid <= awvalid_d;
            frame_done  <= done_d;
            frame_abort <= abort_pulse_d;
            fifo_flush  <= abort_pulse_d;
            last_err    <= last_err_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_ddr_frame_burst_writer.sv
// Bench for ddr_frame_burst_writer: directed scenarios plus random traffic,
// checked every cycle against a frame-progress model.
`timescale 1ns/1ps
module tb_ddr_frame_burst_writer;

    localparam int unsigned   AW = 28, DW = 256, BL = 4, FB = 8, NB = 2, CW = 10;
    localparam logic [AW-1:0] BASE   = 28'h1000000;
    localparam logic [AW-1:0] STRIDE = 28'h0100000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            enable, single_shot, trig, frame_start;
    logic [DW-1:0]   fifo_rd_data;
    logic [CW-1:0]   fifo_count;
    logic            fifo_rd_en, fifo_flush;
    logic [AW-1:0]   axi_awaddr;
    logic [3:0]      axi_awlen;
    logic            axi_awvalid, axi_awready;
    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic            axi_wready, axi_wusero_last;
    logic            busy, frame_done, frame_abort, last_err;
    logic [2:0]      done_buf;

    ddr_frame_burst_writer #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .FRAME_BEATS(FB), .NUM_BUF(NB),
        .BASE_ADDR(BASE), .BUF_STRIDE(STRIDE), .CNT_W(CW)
    ) dut (
        .ddr_clk(clk), .ddr_rstn(rst_n), .enable(enable), .single_shot(single_shot),
        .trig(trig), .frame_start(frame_start), .fifo_rd_data(fifo_rd_data),
        .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en), .fifo_flush(fifo_flush),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wready(axi_wready), .axi_wusero_last(axi_wusero_last), .busy(busy),
        .frame_done(frame_done), .done_buf(done_buf), .frame_abort(frame_abort),
        .last_err(last_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    // Frame-progress model: beats sent in the frame, plus address/burst flags
    typedef enum {PH_IDLE, PH_READY, PH_FRAME} phase_t;
    phase_t        m_phase;
    int            m_sent, m_buf, m_done_buf;
    bit            m_aw, m_burst, m_abort_req, m_armed, m_err, p_done, p_abort;
    logic [AW-1:0] m_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = PH_IDLE; m_sent = 0; m_buf = 0; m_done_buf = 0;
            m_aw = 0; m_burst = 0; m_abort_req = 0; m_armed = 0; m_err = 0;
            p_done = 0; p_abort = 0; m_addr = BASE;
        end else begin
            p_done = 0; p_abort = 0;
            m_armed = m_armed | trig;
            case (m_phase)
                PH_IDLE: if (enable && (!single_shot || m_armed)) m_phase = PH_READY;
                PH_READY: if (frame_start) begin
                    m_phase = PH_FRAME; m_sent = 0; m_armed = 0;
                    m_aw = 0; m_burst = 0; m_abort_req = 0;
                end
                PH_FRAME: begin
                    if (frame_start) m_abort_req = 1;
                    if (m_burst) begin
                        if (axi_wready) begin
                            if (axi_wusero_last != ((m_sent % BL) == BL - 1)) m_err = 1;
                            m_sent++;
                            if (m_sent % BL == 0) begin
                                m_burst = 0;
                                if (m_abort_req) begin
                                    p_abort = 1; m_sent = 0; m_abort_req = 0;
                                end else if (m_sent == FB) begin
                                    p_done = 1; m_done_buf = m_buf;
                                    m_buf = (m_buf + 1) % NB; m_phase = PH_IDLE;
                                end
                            end
                        end
                    end else if (m_aw) begin
                        if (axi_awready) begin m_aw = 0; m_burst = 1; end
                    end else if (m_abort_req) begin
                        p_abort = 1; m_sent = 0; m_abort_req = 0;
                    end else if (fifo_count >= CW'(BL)) begin
                        m_aw = 1;
                        m_addr = AW'(32'(BASE) + 32'(m_buf) * 32'(STRIDE) + 32'(m_sent) * 32'(DW / 8));
                    end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    end

    logic [AW-1:0] aw_log[$];
    int            done_log[$];
    int            pops, aborts;

    // Per-cycle comparison against the model, plus transaction logging
    always @(negedge clk) begin
        if (rst_n) begin
            check("awvalid", 256'(axi_awvalid), 256'(m_aw));
            if (m_aw) check("awaddr", 256'(axi_awaddr), 256'(m_addr));
            check("busy", 256'(busy), 256'(m_phase == PH_FRAME));
            check("rd_en", 256'(fifo_rd_en), 256'(m_phase == PH_FRAME && m_burst && axi_wready));
            check("frame_done", 256'(frame_done), 256'(p_done));
            check("frame_abort", 256'(frame_abort), 256'(p_abort));
            check("fifo_flush", 256'(fifo_flush), 256'(p_abort));
            check("done_buf", 256'(done_buf), 256'(m_done_buf));
            check("last_err", 256'(last_err), 256'(m_err));
            check("awlen", 256'(axi_awlen), 256'(BL - 1));
            check("wstrb", 256'(axi_wstrb), 256'(32'hFFFF_FFFF));
            check("wdata", axi_wdata, fifo_rd_data);
            if (axi_awvalid && axi_awready) aw_log.push_back(axi_awaddr);
            if (fifo_rd_en) pops++;
            if (frame_done) done_log.push_back(int'(done_buf));
            if (frame_abort) aborts++;
        end
    end

    bit rnd_mode = 0, tog_mode = 0, inj_bad = 0;

    task automatic tick();
        bit exp_last, bad;
        @(posedge clk);
        #1;
        frame_start = 0;
        trig = 0;
        if (rnd_mode) begin
            axi_awready  = ($urandom_range(0, 2) != 0);
            axi_wready   = ($urandom_range(0, 3) != 0);
            fifo_count   = CW'($urandom_range(0, 8));
            frame_start  = ($urandom_range(0, 29) == 0);
            trig         = ($urandom_range(0, 24) == 0);
            enable       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 149) == 0) single_shot = ~single_shot;
            fifo_rd_data = {8{$urandom}};
        end else if (tog_mode) begin
            axi_wready = ~axi_wready;
        end
        exp_last = ((m_sent % BL) == BL - 1);
        bad = inj_bad && m_phase == PH_FRAME && m_burst && exp_last && axi_wready;
        axi_wusero_last = exp_last ^ bad;
        if (bad) inj_bad = 0;
    endtask

    task automatic pulse_fs();
        frame_start = 1;
        tick();
    endtask

    task automatic do_reset();
        rnd_mode = 0; tog_mode = 0; inj_bad = 0;
        enable = 1; single_shot = 0; trig = 0; frame_start = 0;
        fifo_count = CW'(8); axi_awready = 1; axi_wready = 1; axi_wusero_last = 0;
        fifo_rd_data = {8{32'hA5C3_0F1E}};
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_awlen", 256'(axi_awlen), 256'(3));
        check("rst_awaddr", 256'(axi_awaddr), 256'(28'h1000000));
        check("rst_awvalid", 256'(axi_awvalid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done_buf", 256'(done_buf), 256'(0));
        check("rst_last_err", 256'(last_err), 256'(0));
        aw_log.delete(); done_log.delete(); pops = 0; aborts = 0;
        rst_n = 1;
    endtask

    initial begin
        #2;
        // Continuous capture and buffer rotation
        do_reset();
        tick(); tick();
        pulse_fs(); repeat (20) tick();
        check("basic_nbursts", 256'(aw_log.size()), 256'(2));
        check("basic_addr0", 256'(aw_log[0]), 256'(28'h1000000));
        check("basic_addr1", 256'(aw_log[1]), 256'(28'h1000080));
        check("basic_pops", 256'(pops), 256'(8));
        check("basic_ndone", 256'(done_log.size()), 256'(1));
        check("basic_done_buf", 256'(done_log[0]), 256'(0));
        pulse_fs(); repeat (20) tick();
        pulse_fs(); repeat (20) tick();
        check("rot_nbursts", 256'(aw_log.size()), 256'(6));
        check("rot_addr_f1", 256'(aw_log[2]), 256'(28'h1100000));
        check("rot_addr_f2", 256'(aw_log[4]), 256'(28'h1000000));
        check("rot_done1", 256'(done_log[1]), 256'(1));
        check("rot_done2", 256'(done_log[2]), 256'(0));

        // Address and write backpressure
        do_reset();
        axi_awready = 0; tog_mode = 1;
        tick(); tick();
        pulse_fs(); repeat (6) tick();
        check("bp_awvalid_held", 256'(axi_awvalid), 256'(1));
        check("bp_awaddr_held", 256'(axi_awaddr), 256'(28'h1000000));
        axi_awready = 1;
        repeat (40) tick();
        check("bp_pops", 256'(pops), 256'(8));
        check("bp_ndone", 256'(done_log.size()), 256'(1));

        // Starvation: a short FIFO holds the address phase off
        do_reset();
        fifo_count = CW'(3);
        tick(); tick();
        pulse_fs(); repeat (6) tick();
        check("starve_hold", 256'(axi_awvalid), 256'(0));
        check("starve_busy", 256'(busy), 256'(1));
        fifo_count = CW'(4);
        check("starve_same_cycle", 256'(axi_awvalid), 256'(0));
        tick();
        check("starve_rise", 256'(axi_awvalid), 256'(1));
        fifo_count = CW'(8);
        repeat (20) tick();

        // Restart during beat 2 of burst 0
        do_reset();
        tick(); tick();
        pulse_fs();
        for (int i = 0; i < 20 && !(m_burst && m_sent == 2); i++) tick();
        pulse_fs(); repeat (2) tick();
        check("abort_pulse", 256'(aborts), 256'(1));
        check("abort_pops", 256'(pops), 256'(4));
        check("abort_no_done", 256'(done_log.size()), 256'(0));
        repeat (20) tick();
        check("abort_restart_addr", 256'(aw_log[1]), 256'(28'h1000000));
        check("abort_then_done", 256'(done_log.size()), 256'(1));
        check("abort_same_buf", 256'(done_log[0]), 256'(0));

        // Single-shot arming and last-beat cross-check
        do_reset();
        single_shot = 1;
        tick(); tick();
        pulse_fs(); repeat (10) tick();
        check("ss_unarmed", 256'(aw_log.size()), 256'(0));
        check("ss_unarmed_busy", 256'(busy), 256'(0));
        trig = 1; tick(); tick();
        pulse_fs(); repeat (20) tick();
        check("ss_one_frame", 256'(done_log.size()), 256'(1));
        pulse_fs(); repeat (10) tick();
        check("ss_second_ignored", 256'(aw_log.size()), 256'(2));
        check("ss_no_err", 256'(last_err), 256'(0));
        trig = 1; tick(); tick();
        inj_bad = 1;
        pulse_fs(); repeat (20) tick();
        check("ss_last_err", 256'(last_err), 256'(1));
        check("ss_err_frame_done", 256'(done_log.size()), 256'(2));

        // Random traffic
        do_reset();
        rnd_mode = 1;
        repeat (4000) tick();
        rnd_mode = 0;
        tick();
        check("rnd_activity", 256'(done_log.size() > 0), 256'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
